rand_server: RTL and testbench

- Shares one Galois LFSR pseudo-random source between N requesters.
- Round-robin arbitration; each serviced request gets a unique LFSR value on a shared data bus, qualified by a one-hot ack pulse.
- Sequences seeding: loads the seed, substitutes a non-zero value for a zero seed, then discards WARMUP steps before serving.
- Sits between the random-number datapath and consumers (test-pattern generators, jitter sources, game logic).

---
 rtl/rand_pkg.sv | 27 ++
 rtl/rand_lfsr_core.sv | 30 +++
 rtl/rand_server.sv | 120 ++++++++++++
 tb/tb_rand_server.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and the Galois LFSR step function for the random-number server.
package rand_pkg;

    localparam logic [15:0] SEED_DEFAULT_16 = 16'hACE1;

    typedef enum logic {
        ST_WARMUP,
        ST_SERVE
    } state_t;

    // Width-generic step: operates on the low w bits of a 64-bit container (7 <= w <= 64).
    function automatic logic [63:0] lfsr_next(input logic [63:0] l, input int w);
        logic [63:0] n;
        n = '0;
        for (int i = 0; i < 63; i++) begin
            if (i < w - 6) n[i] = l[i+1];
        end
        n[w-1] = l[0];
        n[w-2] = l[w-1];
        n[w-3] = l[0] ^ l[w-2];
        n[w-4] = l[0] ^ l[w-3];
        n[w-5] = l[w-4];
        n[w-6] = l[0] ^ l[w-5];
        return n;
    endfunction

endpackage

// File: rtl/rand_lfsr_core.sv
// W-bit Galois LFSR register; load has priority over step, both take effect at the next edge.
module rand_lfsr_core
    import rand_pkg::*;
#(
    parameter int             W            = 16,
    parameter logic [W-1:0]   SEED_DEFAULT = W'(SEED_DEFAULT_16)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_step,
    output logic [W-1:0] o_lfsr
);

    logic [W-1:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED_DEFAULT;
        end else if (i_load) begin
            r_lfsr <= i_load_val;
        end else if (i_step) begin
            r_lfsr <= W'(lfsr_next(64'(r_lfsr), W));
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/rand_server.sv
// Round-robin server handing out unique LFSR values to N requesters; ack/data one cycle after req.
// Requests are held (not dropped) while busy during seed warm-up; no acks issued then.
module rand_server
    import rand_pkg::*;
#(
    parameter int             W            = 16,
    parameter int             N            = 4,
    parameter int             WARMUP       = 4,
    parameter logic [W-1:0]   SEED_DEFAULT = W'(SEED_DEFAULT_16)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_reseed,
    input  logic [W-1:0] i_seed,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_ack,
    output logic [W-1:0] o_data,
    output logic         o_busy
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(WARMUP + 1);

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [PW-1:0]  r_ptr, w_ptr_nxt;
    logic [N-1:0]   r_ack, w_ack_nxt;
    logic [W-1:0]   r_data, w_data_nxt;

    logic [N-1:0]   w_elig;
    logic           w_found;
    logic [PW-1:0]  w_win;
    logic           w_load;
    logic           w_step;
    logic [W-1:0]   w_seed_val;
    logic [W-1:0]   w_lfsr;

    // Returns {found, index} of the first set bit scanning ptr, ptr+1, ... modulo N.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] elig, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (elig[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    // The requester acked this cycle sits out one round so others get priority.
    assign w_elig           = i_req & ~r_ack;
    assign {w_found, w_win} = rr_pick(w_elig, r_ptr);
    assign w_seed_val       = (i_seed == '0) ? SEED_DEFAULT : i_seed;

    rand_lfsr_core #(
        .W            (W),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_seed_val),
        .i_step     (w_step),
        .o_lfsr     (w_lfsr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_ack_nxt   = '0;
        w_data_nxt  = r_data;
        w_load      = 1'b0;
        w_step      = 1'b0;

        if (i_reseed) begin
            w_load      = 1'b1;
            w_state_nxt = ST_WARMUP;
            w_cnt_nxt   = CW'(WARMUP);
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    w_step    = 1'b1;
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) w_state_nxt = ST_SERVE;
                end
                ST_SERVE: begin
                    if (w_found) begin
                        w_ack_nxt[w_win] = 1'b1;
                        w_data_nxt       = w_lfsr;
                        w_step           = 1'b1;
                        w_ptr_nxt        = (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
                    end
                end
                default: w_state_nxt = ST_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WARMUP;
            r_cnt   <= CW'(WARMUP);
            r_ptr   <= '0;
            r_ack   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ack   <= w_ack_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign o_ack  = r_ack;
    assign o_data = r_data;
    assign o_busy = (r_state == ST_WARMUP);

endmodule

// File: tb/tb_rand_server.sv
// Scenario bench for rand_server against a cycle-level behavioural model.
module tb_rand_server;

    localparam int           W        = 16;
    localparam int           N        = 4;
    localparam int           WARMUP   = 4;
    localparam logic [W-1:0] SEED_DEF = 16'h0001;
    localparam logic [W-1:0] TAPS     = W'((1 << (W-1)) | (1 << (W-3)) | (1 << (W-4)) | (1 << (W-6)));

    logic         clk = 1'b0;
    logic         rst;
    logic         i_reseed;
    logic [W-1:0] i_seed;
    logic [N-1:0] i_req;
    logic [N-1:0] o_ack;
    logic [W-1:0] o_data;
    logic         o_busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_lfsr, m_data;
    logic [N-1:0] m_ack;
    int           m_warm, m_ptr;

    rand_server #(
        .W            (W),
        .N            (N),
        .WARMUP       (WARMUP),
        .SEED_DEFAULT (SEED_DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_reseed (i_reseed),
        .i_seed   (i_seed),
        .i_req    (i_req),
        .o_ack    (o_ack),
        .o_data   (o_data),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_next(input logic [W-1:0] l);
        return (l >> 1) ^ (l[0] ? TAPS : '0);
    endfunction

    function automatic logic [W-1:0] ref_advance(input logic [W-1:0] l, input int steps);
        logic [W-1:0] v;
        v = l;
        for (int i = 0; i < steps; i++) v = ref_next(v);
        return v;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED_DEF;
        m_warm = WARMUP;
        m_ptr  = 0;
        m_ack  = '0;
        m_data = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] prev;
        int           win, idx;
        prev  = m_ack;
        m_ack = '0;
        if (i_reseed) begin
            m_lfsr = (i_seed == '0) ? SEED_DEF : i_seed;
            m_warm = WARMUP;
        end else if (m_warm > 0) begin
            m_lfsr = ref_next(m_lfsr);
            m_warm--;
        end else begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && i_req[idx] && !prev[idx]) win = idx;
            end
            if (win >= 0) begin
                m_ack[win] = 1'b1;
                m_data     = m_lfsr;
                m_lfsr     = ref_next(m_lfsr);
                m_ptr      = (win + 1) % N;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i_reseed = 1'b0;
        i_seed   = '0;
        i_req    = '0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Busy for exactly WARMUP cycles after release, then the first value is SEED_DEF advanced WARMUP times.
    task automatic test_warmup_first_ack(input string tag);
        int           n;
        logic [W-1:0] exp;
        i_req = 4'b0001;
        n     = 0;
        while (o_busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (n != WARMUP) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, WARMUP); end
        tick();
        exp = ref_advance(SEED_DEF, WARMUP);
        checks++;
        if (o_ack !== 4'b0001) begin errors++; $display("FAIL %s first_ack: got %b expected 0001", tag, o_ack); end
        checks++;
        if (o_data !== exp) begin errors++; $display("FAIL %s first_data: got %h expected %h", tag, o_data, exp); end
        i_req = '0;
        tick();
        checks++;
        if (o_ack !== 4'b0000) begin errors++; $display("FAIL %s ack_pulse: got %b expected 0000", tag, o_ack); end
        checks++;
        if (o_data !== exp) begin errors++; $display("FAIL %s data_hold: got %h expected %h", tag, o_data, exp); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_ack !== '0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", o_ack); end
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0000", o_data); end
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", o_busy); end
        rst = 1'b0;
        test_warmup_first_ack("reset");
    endtask

    task automatic test_reseed_mask();
        logic [W-1:0] seeds [2];
        logic [W-1:0] exp;
        int           n;
        seeds[0] = 16'h0001;
        seeds[1] = W'($urandom_range(1, 16'hFFFF));
        for (int s = 0; s < 2; s++) begin
            i_req    = '0;
            i_reseed = 1'b1;
            i_seed   = seeds[s];
            tick();
            i_reseed = 1'b0;
            checks++;
            if (o_busy !== 1'b1) begin errors++; $display("FAIL reseed_busy: got %b expected 1", o_busy); end
            i_req = 4'b0001;
            n     = 0;
            while (o_ack === '0 && n < 50) begin
                n++;
                tick();
            end
            exp = ref_advance(seeds[s], WARMUP);
            checks++;
            if (n != WARMUP + 1) begin errors++; $display("FAIL reseed_latency: got %0d expected %0d", n, WARMUP + 1); end
            checks++;
            if (o_ack !== 4'b0001 || o_data !== exp) begin
                errors++; $display("FAIL reseed_first: ack=%b data=%h expected 0001/%h", o_ack, o_data, exp);
            end
            tick();
            checks++;
            if (o_ack !== 4'b0000) begin errors++; $display("FAIL mask_gap: got %b expected 0000", o_ack); end
            tick();
            checks++;
            if (o_ack !== 4'b0001 || o_data !== ref_next(exp)) begin
                errors++; $display("FAIL mask_second: ack=%b data=%h expected 0001/%h", o_ack, o_data, ref_next(exp));
            end
            i_req = '0;
            tick();
        end
    endtask

    task automatic test_round_robin();
        bit           seen [logic [W-1:0]];
        int           prev_idx;
        logic [W-1:0] prev_data;
        logic [N-1:0] exp_ack;
        i_req = 4'b1111;
        tick();
        checks++;
        if (o_ack !== m_ack || o_data !== m_data) begin
            errors++; $display("FAIL rr_first: ack=%b data=%h expected %b/%h", o_ack, o_data, m_ack, m_data);
        end
        prev_idx = 0;
        for (int i = 0; i < N; i++) if (m_ack[i]) prev_idx = i;
        prev_data       = m_data;
        seen[prev_data] = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            tick();
            exp_ack = '0;
            exp_ack[(prev_idx + 1) % N] = 1'b1;
            checks++;
            if (o_ack !== exp_ack) begin errors++; $display("FAIL rr_ack c=%0d: got %b expected %b", c, o_ack, exp_ack); end
            checks++;
            if (o_data !== ref_next(prev_data)) begin
                errors++; $display("FAIL rr_data c=%0d: got %h expected %h", c, o_data, ref_next(prev_data));
            end
            checks++;
            if (o_data === '0 || seen.exists(o_data)) begin errors++; $display("FAIL rr_unique c=%0d: value %h repeated or zero", c, o_data); end
            seen[o_data] = 1'b1;
            prev_idx     = (prev_idx + 1) % N;
            prev_data    = ref_next(prev_data);
        end
        i_req = '0;
        tick();
    endtask

    task automatic test_zero_seed();
        int           n;
        logic [W-1:0] exp;
        i_reseed = 1'b1;
        i_seed   = '0;
        tick();
        i_reseed = 1'b0;
        i_req    = 4'b0001;
        n        = 0;
        while (o_ack === '0 && n < 50) begin
            n++;
            tick();
        end
        exp = ref_advance(SEED_DEF, WARMUP);
        checks++;
        if (o_data !== exp) begin errors++; $display("FAIL zero_seed_data: got %h expected %h", o_data, exp); end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (o_ack !== m_ack || o_data !== m_data || (o_ack !== '0 && o_data === '0)) begin
                errors++; $display("FAIL zero_seed_seq c=%0d: ack=%b data=%h expected %b/%h", c, o_ack, o_data, m_ack, m_data);
            end
        end
        i_req = '0;
        tick();
    endtask

    task automatic test_reseed_with_req();
        int           n;
        logic [W-1:0] seed, exp;
        do_reset();
        rst = 1'b0;
        n   = 0;
        while (o_busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        seed     = W'($urandom);
        i_req    = 4'b0110;
        i_reseed = 1'b1;
        i_seed   = seed;
        tick();
        i_reseed = 1'b0;
        checks++;
        if (o_ack !== '0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL reseed_req_edge: ack=%b busy=%b expected 0000/1", o_ack, o_busy);
        end
        n = 0;
        while (o_busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (n != WARMUP) begin errors++; $display("FAIL reseed_req_busy: got %0d expected %0d", n, WARMUP); end
        exp = ref_advance((seed == '0) ? SEED_DEF : seed, WARMUP);
        tick();
        checks++;
        if (o_ack !== 4'b0010 || o_data !== exp) begin
            errors++; $display("FAIL reseed_req_r1: ack=%b data=%h expected 0010/%h", o_ack, o_data, exp);
        end
        i_req = 4'b0100;
        tick();
        checks++;
        if (o_ack !== 4'b0100 || o_data !== ref_next(exp)) begin
            errors++; $display("FAIL reseed_req_r2: ack=%b data=%h expected 0100/%h", o_ack, o_data, ref_next(exp));
        end
        i_req = '0;
        tick();
    endtask

    task automatic test_reset_mid_service();
        i_req = 4'b0100;
        tick();
        checks++;
        if (o_ack !== 4'b0100) begin errors++; $display("FAIL mid_ack: got %b expected 0100", o_ack); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (o_ack !== '0 || o_data !== '0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL mid_async: ack=%b data=%h busy=%b expected 0000/0000/1", o_ack, o_data, o_busy);
        end
        @(posedge clk);
        #1;
        i_req = '0;
        rst   = 1'b0;
        test_warmup_first_ack("mid_reset");
    endtask

    task automatic test_random();
        logic [N-1:0] hold;
        do_reset();
        rst  = 1'b0;
        hold = '0;
        for (int c = 0; c < 400; c++) begin
            i_reseed = ($urandom_range(0, 49) == 0);
            i_seed   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            i_req    = hold;
            tick();
            checks++;
            if (o_ack !== m_ack || o_data !== m_data || o_busy !== (m_warm > 0)) begin
                errors++;
                $display("FAIL random c=%0d: ack=%b data=%h busy=%b expected %b/%h/%b",
                         c, o_ack, o_data, o_busy, m_ack, m_data, (m_warm > 0));
            end
            for (int i = 0; i < N; i++) begin
                if (m_ack[i]) hold[i] = 1'b0;
                else if (!hold[i] && $urandom_range(0, 2) == 0) hold[i] = 1'b1;
            end
        end
        i_reseed = 1'b0;
        i_req    = '0;
    endtask

    initial begin
        rst      = 1'b1;
        i_reseed = 1'b0;
        i_seed   = '0;
        i_req    = '0;
        model_reset();
        test_reset();
        test_reseed_mask();
        test_round_robin();
        test_zero_seed();
        test_reseed_with_req();
        test_reset_mid_service();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
